// File: rtl/mission_fsm.sv
// mission_fsm: washer-robot mission controller with debounced sensors and timed phases.
// Optional feature macro CORNER_TIMEOUT_EN adds the CORNER dwell limit and timeout_flag pulse.
module mission_fsm #(
    parameter int CS_W           = 4,
    parameter int N_SENSE        = 2,
    parameter int DEBOUNCE       = 4,
    parameter int GRAB_CYC       = 1000,
    parameter int COLOR_CYC      = 500,
    parameter int DROP_CYC       = 1000,
    parameter int STALL_CYC      = 2000,
    parameter int CORNER_TIMEOUT = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               irs,
    input  logic               ips,
    input  logic [CS_W-1:0]    cs,
    input  logic [N_SENSE-1:0] sense,
    input  logic               corner_found,
    output logic [2:0]         state,
    output logic               enable_searching,
    output logic               enable_corner,
    output logic               emag_on,
    output logic               hbridge_en,
    output logic [CS_W-1:0]    color_id,
    output logic [7:0]         washer_count,
    output logic               timeout_flag
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TMAX = max2(max2(max2(GRAB_CYC, COLOR_CYC), max2(DROP_CYC, STALL_CYC)),
                               CORNER_TIMEOUT);
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int DW   = $clog2(DEBOUNCE) + 1;

    localparam logic [2:0] SEARCH  = 3'd0;
    localparam logic [2:0] AVOID   = 3'd1;
    localparam logic [2:0] GRAB    = 3'd2;
    localparam logic [2:0] COLOR   = 3'd3;
    localparam logic [2:0] CORNER  = 3'd4;
    localparam logic [2:0] DROP    = 3'd5;
    localparam logic [2:0] STALLED = 3'd6;

    // Filter index: 0 = irs, 1 = ips, 2 = stall (OR of all sense channels)
    logic [2:0]    raw;
    logic [2:0]    filt;
    logic [DW-1:0] db_cnt [3];

    assign raw = {|sense, ips, irs};

    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (raw[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
                    filt[i]   <= raw[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic irs_f, ips_f, stall_f;
    assign irs_f   = filt[0];
    assign ips_f   = filt[1];
    assign stall_f = filt[2];

    logic [2:0]      ret_state;
    logic [TW-1:0]   timer;
    logic [2:0]      next_state;
    logic [2:0]      next_ret;
    logic [CS_W-1:0] next_color;
    logic [7:0]      next_count;
    logic            timeout_hit;
    logic            corner_timeout;
    logic            carrying;

`ifdef CORNER_TIMEOUT_EN
    logic [TW-1:0] corner_dwell;

    assign corner_timeout = (state == CORNER) && (corner_dwell == TW'(CORNER_TIMEOUT - 1));

    // Dwell survives AVOID/STALLED excursions; only DROP or SEARCH ends a corner attempt
    always_ff @(posedge clk) begin
        if (reset || next_state == DROP || next_state == SEARCH) corner_dwell <= '0;
        else if (state == CORNER)                              corner_dwell <= corner_dwell + 1'b1;
    end
`else
    assign corner_timeout = 1'b0;
`endif

    always_comb begin
        next_state  = state;
        next_ret    = ret_state;
        next_color  = color_id;
        next_count  = washer_count;
        timeout_hit = 1'b0;
        case (state)
            SEARCH: begin
                if (stall_f) begin
                    next_state = STALLED;
                    next_ret   = SEARCH;
                end else if (ips_f) begin
                    next_state = GRAB;
                end else if (irs_f) begin
                    next_state = AVOID;
                    next_ret   = SEARCH;
                end
            end
            AVOID: begin
                if (stall_f)     next_state = STALLED;
                else if (!irs_f) next_state = ret_state;
            end
            GRAB: begin
                if (timer == TW'(GRAB_CYC - 1)) next_state = COLOR;
            end
            COLOR: begin
                if (timer == TW'(COLOR_CYC - 1)) begin
                    if (cs != '0) begin
                        next_color = cs;
                        next_state = CORNER;
                    end else begin
                        next_state = SEARCH;
                    end
                end
            end
            CORNER: begin
                if (stall_f) begin
                    next_state = STALLED;
                    next_ret   = CORNER;
                end else if (corner_found) begin
                    next_state = DROP;
                end else if (corner_timeout) begin
                    next_state  = DROP;
                    timeout_hit = 1'b1;
                end else if (irs_f) begin
                    next_state = AVOID;
                    next_ret   = CORNER;
                end
            end
            DROP: begin
                if (timer == TW'(DROP_CYC - 1)) begin
                    next_state = SEARCH;
                    if (washer_count != 8'hFF) next_count = washer_count + 8'd1;
                end
            end
            STALLED: begin
                if (timer == TW'(STALL_CYC - 1)) next_state = ret_state;
            end
            default: next_state = SEARCH;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state
    assign carrying = (next_state == GRAB) || (next_state == COLOR) || (next_state == CORNER) ||
                      (((next_state == AVOID) || (next_state == STALLED)) && (next_ret == CORNER));

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= SEARCH;
            ret_state        <= SEARCH;
            timer            <= '0;
            enable_searching <= 1'b0;
            enable_corner    <= 1'b0;
            emag_on          <= 1'b0;
            hbridge_en       <= 1'b1;
            color_id         <= '0;
            washer_count     <= '0;
            timeout_flag     <= 1'b0;
        end else begin
            state            <= next_state;
            ret_state        <= next_ret;
            timer            <= (next_state != state) ? '0 : timer + 1'b1;
            enable_searching <= (next_state == SEARCH);
            enable_corner    <= (next_state == CORNER);
            emag_on          <= carrying;
            hbridge_en       <= (next_state != STALLED);
            color_id         <= next_color;
            washer_count     <= next_count;
            timeout_flag     <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_mission_fsm.sv
// tb_mission_fsm: scoreboard bench for mission_fsm; a behavioural model queues expected
// outputs every clock and a negedge monitor pops and compares them against the DUT.
module tb_mission_fsm;

    localparam int CS_W  = 4;
    localparam int NS    = 2;
    localparam int DEB   = 2;
    localparam int T_GRB = 4;
    localparam int T_COL = 3;
    localparam int T_DRP = 4;
    localparam int T_STL = 5;
    localparam int T_CTO = 20;

    localparam int S_SEARCH = 0, S_AVOID = 1, S_GRAB = 2, S_COLOR = 3;
    localparam int S_CORNER = 4, S_DROP = 5, S_STALLED = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            irs, ips, corner_found;
    logic [CS_W-1:0] cs;
    logic [NS-1:0]   sense;
    logic [2:0]      state;
    logic            enable_searching, enable_corner, emag_on, hbridge_en, timeout_flag;
    logic [CS_W-1:0] color_id;
    logic [7:0]      washer_count;

    mission_fsm #(
        .CS_W(CS_W), .N_SENSE(NS), .DEBOUNCE(DEB), .GRAB_CYC(T_GRB), .COLOR_CYC(T_COL),
        .DROP_CYC(T_DRP), .STALL_CYC(T_STL), .CORNER_TIMEOUT(T_CTO)
    ) dut (
        .clk(clk), .reset(reset), .irs(irs), .ips(ips), .cs(cs), .sense(sense),
        .corner_found(corner_found), .state(state), .enable_searching(enable_searching),
        .enable_corner(enable_corner), .emag_on(emag_on), .hbridge_en(hbridge_en),
        .color_id(color_id), .washer_count(washer_count), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      st;
        logic            es, ec, em, hb, tf;
        logic [CS_W-1:0] col;
        logic [7:0]      cnt;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // ---------------- behavioural reference model ----------------
    int          m_state, m_ret, m_in_state, m_corner_time, m_color, m_count, m_next;
    bit          m_tf;
    int unsigned hist[3];
    bit          filt[3];
    bit          smp[3];
    exp_t        e;

    function automatic int phase_len(input int s);
        case (s)
            S_GRAB:    return T_GRB;
            S_COLOR:   return T_COL;
            S_DROP:    return T_DRP;
            S_STALLED: return T_STL;
            default:   return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_state = S_SEARCH; m_ret = S_SEARCH; m_in_state = 0; m_corner_time = 0;
            m_color = 0; m_count = 0;
            for (int i = 0; i < 3; i++) begin hist[i] = 0; filt[i] = 0; end
            e.st = 3'd0; e.es = 0; e.ec = 0; e.em = 0; e.hb = 1; e.tf = 0; e.col = '0; e.cnt = '0;
        end else begin
            smp[0] = irs; smp[1] = ips; smp[2] = (sense != '0);
            m_next = m_state;
            m_tf   = 0;
            if (phase_len(m_state) != 0) begin
                // timed phase: leave once the full phase length has been spent here
                if (m_in_state + 1 == phase_len(m_state)) begin
                    if (m_state == S_GRAB) m_next = S_COLOR;
                    else if (m_state == S_STALLED) m_next = m_ret;
                    else if (m_state == S_DROP) begin
                        m_next = S_SEARCH;
                        m_count = (m_count < 255) ? m_count + 1 : 255;
                    end else if (cs != 0) begin
                        m_color = cs; m_next = S_CORNER;
                    end else m_next = S_SEARCH;
                end
            end else if (m_state == S_SEARCH) begin
                if (filt[2])      begin m_next = S_STALLED; m_ret = S_SEARCH; end
                else if (filt[1]) m_next = S_GRAB;
                else if (filt[0]) begin m_next = S_AVOID; m_ret = S_SEARCH; end
            end else if (m_state == S_AVOID) begin
                if (filt[2])       m_next = S_STALLED;
                else if (!filt[0]) m_next = m_ret;
            end else if (m_state == S_CORNER) begin
                if (filt[2])           begin m_next = S_STALLED; m_ret = S_CORNER; end
                else if (corner_found) m_next = S_DROP;
`ifdef CORNER_TIMEOUT_EN
                else if (m_corner_time + 1 == T_CTO) begin m_next = S_DROP; m_tf = 1; end
`endif
                else if (filt[0])      begin m_next = S_AVOID; m_ret = S_CORNER; end
            end else m_next = S_SEARCH;

            if (m_next == S_DROP || m_next == S_SEARCH) m_corner_time = 0;
            else if (m_state == S_CORNER)               m_corner_time++;
            m_in_state = (m_next != m_state) ? 0 : m_in_state + 1;
            m_state    = m_next;

            // debounce: accept a new level once the last DEB samples all disagree with it
            for (int i = 0; i < 3; i++) begin
                hist[i] = ((hist[i] << 1) | int'(smp[i])) & ((1 << DEB) - 1);
                if (hist[i] == (filt[i] ? 0 : (1 << DEB) - 1)) filt[i] = !filt[i];
            end

            e.st  = 3'(m_state);
            e.es  = (m_state == S_SEARCH);
            e.ec  = (m_state == S_CORNER);
            e.em  = (m_state == S_GRAB || m_state == S_COLOR || m_state == S_CORNER) ||
                    ((m_state == S_AVOID || m_state == S_STALLED) && m_ret == S_CORNER);
            e.hb  = (m_state != S_STALLED);
            e.tf  = m_tf;
            e.col = CS_W'(m_color);
            e.cnt = 8'(m_count);
        end
        expq.push_back(e);
    end

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (expq.size() > 0) begin
            x = expq.pop_front();
            chk("state",            32'(state),            32'(x.st));
            chk("enable_searching", 32'(enable_searching), 32'(x.es));
            chk("enable_corner",    32'(enable_corner),    32'(x.ec));
            chk("emag_on",          32'(emag_on),          32'(x.em));
            chk("hbridge_en",       32'(hbridge_en),       32'(x.hb));
            chk("timeout_flag",     32'(timeout_flag),     32'(x.tf));
            chk("color_id",         32'(color_id),         32'(x.col));
            chk("washer_count",     32'(washer_count),     32'(x.cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (m_state != s && n < budget) begin tick(1); n++; end
        n_checks++;
        if (m_state != s) begin
            n_fail++;
            $display("FAIL wait_state: got %0d required %0d after %0d cycles", m_state, s, budget);
        end
    endtask

    task automatic start_mission(input logic [CS_W-1:0] color);
        cs  = color;
        ips = 1'b1; tick(3); ips = 1'b0;
    endtask

    task automatic finish_corner();
        corner_found = 1'b1; tick(3); corner_found = 1'b0;
        wait_state(S_SEARCH, 20);
    endtask

    task automatic clear_inputs();
        irs = 0; ips = 0; cs = '0; sense = '0; corner_found = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);

        // full mission with color 5
        start_mission(4'h5);
        wait_state(S_CORNER, 30);
        finish_corner();
        tick(3);

        // debounce: glitch, then a held obstacle
        irs = 1; tick(1); irs = 0; tick(4);
        irs = 1; tick(4); irs = 0; tick(6);

        // obstacle while carrying to the corner
        start_mission(4'h9);
        wait_state(S_CORNER, 30);
        irs = 1; tick(5); irs = 0; tick(5);
        finish_corner();

        // stall beats obstacle
        sense = 2'b10; irs = 1; tick(3); sense = '0; irs = 0; tick(12);

        // stall while carrying returns to CORNER
        start_mission(4'h3);
        wait_state(S_CORNER, 30);
        sense = 2'b01; tick(3); sense = '0; tick(10);
        finish_corner();

        // lost washer
        start_mission(4'h0); tick(15);

        // corner dwell: timeout path when enabled, otherwise an indefinite wait
        start_mission(4'h7);
        wait_state(S_CORNER, 30);
        tick(T_CTO + 6);
        corner_found = 1; tick(3); corner_found = 0;
        wait_state(S_SEARCH, 20);

        // randomised activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0)  irs = ~irs;
            if ($urandom_range(0, 9) == 0)  ips = ~ips;
            if ($urandom_range(0, 29) == 0) sense = NS'($urandom_range(0, 3));
            corner_found = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 5) == 0)  cs = CS_W'($urandom_range(0, 15));
            tick(1);
        end
        clear_inputs();
        reset = 1'b1; tick(2); reset = 1'b0; tick(1);

        // drive the washer count into saturation
        for (int k = 0; k < 257; k++) begin
            start_mission(CS_W'($urandom_range(1, 15)));
            wait_state(S_CORNER, 30);
            finish_corner();
        end
        tick(2);

        // reset in the middle of GRAB
        start_mission(4'h5);
        wait_state(S_GRAB, 5);
        tick(1);
        reset = 1'b1; tick(1); reset = 1'b0;
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
